// File: rtl/grid_frame_sched.sv
// grid_frame_sched: owns the 8x18 back buffer and serialises cell writes, line-clear passes
// and end-of-frame swaps so the display only ever sees whole-operation snapshots.
module grid_frame_sched #(
    parameter int COLS  = 8,
    parameter int ROWS  = 18,
    parameter int CELLS = COLS*ROWS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [7:0]       wr_x,
    input  logic [7:0]       wr_y,
    input  logic             wr_val,
    output logic             wr_err,
    input  logic             clear_req,
    output logic             clear_busy,
    output logic             clear_done,
    output logic [4:0]       lines_cleared,
    input  logic             frame_end,
    output logic [CELLS-1:0] data_swap,
    output logic             draw_finish
);
    typedef enum logic [1:0] {IDLE, SWAP, SCAN, SHIFT} state_t;
    state_t state, state_n;
    logic [CELLS-1:0] grid;
    logic swap_pend, clear_pend, row_full, in_range;
    logic [4:0] row_ptr, shift_ptr, count;
    logic [7:0] wr_idx, row_idx, sh_idx, src_idx;
    assign wr_idx     = {wr_y[4:0], wr_x[2:0]};
    assign row_idx    = {row_ptr, 3'b000};
    assign sh_idx     = {shift_ptr, 3'b000};
    assign src_idx    = sh_idx - 8'd8;
    assign row_full   = &grid[row_idx +: 8];
    assign in_range   = wr_x < 8'(COLS) && wr_y < 8'(ROWS);
    assign wr_ready   = state == IDLE && !swap_pend && !clear_pend;
    assign clear_busy = clear_pend || state == SCAN || state == SHIFT;
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = swap_pend ? SWAP : clear_pend ? SCAN : IDLE;
            SWAP:    state_n = IDLE;
            SCAN:    state_n = row_full ? SHIFT : row_ptr == 5'd0 ? IDLE : SCAN;
            SHIFT:   state_n = shift_ptr == 5'd0 ? SCAN : SHIFT;
            default: state_n = IDLE;
        endcase
    end
    // Pending requests arriving in any state merge into one flag; swaps win over passes in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grid          <= '0;
            data_swap     <= '0;
            draw_finish   <= 1'b0;
            wr_err        <= 1'b0;
            clear_done    <= 1'b0;
            lines_cleared <= '0;
            swap_pend     <= 1'b0;
            clear_pend    <= 1'b0;
            row_ptr       <= '0;
            shift_ptr     <= '0;
            count         <= '0;
        end else begin
            draw_finish <= 1'b0;
            wr_err      <= 1'b0;
            clear_done  <= 1'b0;
            swap_pend   <= frame_end || (swap_pend && state != SWAP);
            clear_pend  <= clear_req || (clear_pend && !(state == IDLE && !swap_pend));
            unique case (state)
                IDLE:
                    if (!swap_pend && clear_pend) begin
                        row_ptr <= 5'(ROWS-1);
                        count   <= '0;
                    end else if (wr_ready && wr_valid) begin
                        if (in_range) grid[wr_idx] <= wr_val;
                        else          wr_err       <= 1'b1;
                    end
                SWAP: begin
                    data_swap   <= grid;
                    draw_finish <= 1'b1;
                end
                SCAN:
                    if (row_full) begin
                        shift_ptr <= row_ptr;
                        count     <= count == 5'd31 ? count : count + 5'd1;
                    end else if (row_ptr == 5'd0) begin
                        clear_done    <= 1'b1;
                        lines_cleared <= count;
                    end else
                        row_ptr <= row_ptr - 5'd1;
                SHIFT:
                    if (shift_ptr != 5'd0) begin
                        grid[sh_idx +: 8] <= grid[src_idx +: 8];
                        shift_ptr         <= shift_ptr - 5'd1;
                    end else
                        grid[7:0] <= '0;
                default: ;
            endcase
        end
    end
endmodule
